// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline front-end hazard controller.
// The counter-width helper sizes the shared timer used by MD_BUSY and EXC_DRAIN.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MD_BUSY   = 2'd1,
        ST_EXC_DRAIN = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0020;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

    // Control bundle presented to the pipeline registers, in port order.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_flush;
        logic pc_sel_exc;
        logic epc_write;
        logic muldiv_busy;
        logic muldiv_cancel;
    } ctrl_t;

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the MIPS datapath (master) and the
// front-end sequencer (slave): decode/EX hazard inputs and register controls.
interface pipe_hazard_ctrl_if;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_is_muldiv;
    logic       id_reads_hilo;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       branch_redirect;
    logic       btb_mispredict;
    logic       exception;

    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       ex_flush;
    logic       pc_sel_exc;
    logic       epc_write;
    logic       muldiv_busy;
    logic       muldiv_cancel;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_is_muldiv, id_reads_hilo,
               ex_mem_read, ex_rt, branch_redirect, btb_mispredict, exception,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_flush,
               pc_sel_exc, epc_write, muldiv_busy, muldiv_cancel
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_is_muldiv, id_reads_hilo,
               ex_mem_read, ex_rt, branch_redirect, btb_mispredict, exception,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_flush,
               pc_sel_exc, epc_write, muldiv_busy, muldiv_cancel
    );

endinterface

// File: rtl/hazard_cnt.sv
// Loadable down-counter with zero flag; shared by the mult/div occupancy
// timer and the post-exception drain timer. Saturates at zero.
module hazard_cnt #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end sequencer for the 5-stage MIPS pipeline: load-use stalls, redirects,
// mult/div occupancy and precise exceptions. Outputs are combinational, forced low in reset.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 32,
    parameter int unsigned EXC_DRAIN  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam int unsigned         CNT_W    = cnt_width(MULDIV_LAT, EXC_DRAIN);
    localparam logic [CNT_W-1:0]    MD_LOAD  = CNT_W'(MULDIV_LAT - 1);
    localparam logic [CNT_W-1:0]    EXC_LOAD = CNT_W'(EXC_DRAIN - 1);

    state_e           state_q, state_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             load_use;
    logic             exc_take;
    logic             redirect;
    ctrl_t            ctrl_c;
    ctrl_t            ctrl_o;

    hazard_cnt #(.WIDTH(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    assign load_use = hz.ex_mem_read && (hz.ex_rt != REG_ZERO) &&
                      ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
    assign exc_take = hz.exception && (state_q != ST_EXC_DRAIN);
    assign redirect = hz.btb_mispredict || hz.branch_redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path through this block can infer a latch.
        state_d            = state_q;
        cnt_load           = 1'b0;
        cnt_load_val       = '0;
        cnt_dec            = 1'b0;
        ctrl_c             = '0;
        ctrl_c.pc_write    = 1'b1;
        ctrl_c.if_id_write = 1'b1;
        ctrl_c.muldiv_busy = (state_q == ST_MD_BUSY);

        if (exc_take) begin
            ctrl_c.ex_flush      = 1'b1;
            ctrl_c.id_ex_bubble  = 1'b1;
            ctrl_c.if_id_flush   = 1'b1;
            ctrl_c.pc_sel_exc    = 1'b1;
            ctrl_c.epc_write     = 1'b1;
            ctrl_c.muldiv_cancel = (state_q == ST_MD_BUSY);
            state_d              = ST_EXC_DRAIN;
            cnt_load             = 1'b1;
            cnt_load_val         = EXC_LOAD;
        end else begin
            if (hz.btb_mispredict) begin
                ctrl_c.if_id_flush  = 1'b1;
                ctrl_c.id_ex_bubble = 1'b1;
            end else if (hz.branch_redirect) begin
                ctrl_c.if_id_flush  = 1'b1;
            end else if (load_use ||
                         // HI/LO readers wait until the final busy cycle, when the result is ready.
                         ((state_q == ST_MD_BUSY) && hz.id_reads_hilo && !cnt_zero)) begin
                ctrl_c.pc_write     = 1'b0;
                ctrl_c.if_id_write  = 1'b0;
                ctrl_c.id_ex_bubble = 1'b1;
            end

            unique case (state_q)
                ST_RUN: begin
                    if (hz.id_is_muldiv && !redirect && !load_use) begin
                        state_d      = ST_MD_BUSY;
                        cnt_load     = 1'b1;
                        cnt_load_val = MD_LOAD;
                    end
                end
                ST_MD_BUSY, ST_EXC_DRAIN: begin
                    if (cnt_zero) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign ctrl_o = rst_n ? ctrl_c : '0;

    assign hz.pc_write      = ctrl_o.pc_write;
    assign hz.if_id_write   = ctrl_o.if_id_write;
    assign hz.if_id_flush   = ctrl_o.if_id_flush;
    assign hz.id_ex_bubble  = ctrl_o.id_ex_bubble;
    assign hz.ex_flush      = ctrl_o.ex_flush;
    assign hz.pc_sel_exc    = ctrl_o.pc_sel_exc;
    assign hz.epc_write     = ctrl_o.epc_write;
    assign hz.muldiv_busy   = ctrl_o.muldiv_busy;
    assign hz.muldiv_cancel = ctrl_o.muldiv_cancel;

    a_no_flush_while_stalled: assert property (@(posedge clk) disable iff (!rst_n)
        !(hz.if_id_flush && !hz.if_id_write));

    // A mult/div reaching EX during the drain would go untracked.
    a_no_muldiv_in_drain: assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q == ST_EXC_DRAIN) && hz.id_is_muldiv) |-> (!hz.if_id_write || hz.if_id_flush));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios plus random
// traffic, compared against a cycle-count reference model of the pipeline rules.
module tb_pipe_hazard_ctrl;

    localparam int MD_LAT = 4;
    localparam int DRAIN  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl #(.MULDIV_LAT(MD_LAT), .EXC_DRAIN(DRAIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] ex_rt;
        logic       uses_rt;
        logic       muldiv;
        logic       hilo;
        logic       mem_read;
        logic       br;
        logic       btb;
        logic       exc;
    } stim_t;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Reference model: remaining busy cycles and remaining drain cycles.
    int md_left    = 0;
    int drain_left = 0;

    function automatic logic [8:0] dut_out();
        return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble,
                bus.ex_flush, bus.pc_sel_exc, bus.epc_write, bus.muldiv_busy, bus.muldiv_cancel};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rs: 5'd0, rt: 5'd0, ex_rt: 5'd0, uses_rt: 1'b0, muldiv: 1'b0, hilo: 1'b0,
              mem_read: 1'b0, br: 1'b0, btb: 1'b0, exc: 1'b0};
        return s;
    endfunction

    function automatic bit is_load_use(input stim_t s);
        return s.mem_read && (s.ex_rt != 0) &&
               ((s.ex_rt == s.rs) || (s.uses_rt && (s.ex_rt == s.rt)));
    endfunction

    function automatic logic [8:0] model_out(input stim_t s);
        bit pcw, ifw, fl, bub, exf, vec, epc, busy, cancel;
        pcw = 1; ifw = 1; fl = 0; bub = 0; exf = 0; vec = 0; epc = 0; cancel = 0;
        busy = (md_left > 0);
        if (s.exc && drain_left == 0) begin
            fl = 1; bub = 1; exf = 1; vec = 1; epc = 1;
            cancel = busy;
        end else if (s.btb) begin
            fl = 1; bub = 1;
        end else if (s.br) begin
            fl = 1;
        end else if (is_load_use(s) || (busy && s.hilo && md_left > 1)) begin
            pcw = 0; ifw = 0; bub = 1;
        end
        return {pcw, ifw, fl, bub, exf, vec, epc, busy, cancel};
    endfunction

    task automatic model_next(input stim_t s);
        if (s.exc && drain_left == 0) begin
            md_left    = 0;
            drain_left = DRAIN;
        end else if (drain_left > 0) begin
            drain_left--;
        end else if (md_left > 0) begin
            md_left--;
        end else if (s.muldiv && !s.btb && !s.br && !is_load_use(s)) begin
            md_left = MD_LAT;
        end
    endtask

    task automatic apply(input stim_t s);
        bus.id_rs           = s.rs;
        bus.id_rt           = s.rt;
        bus.id_uses_rt      = s.uses_rt;
        bus.id_is_muldiv    = s.muldiv;
        bus.id_reads_hilo   = s.hilo;
        bus.ex_mem_read     = s.mem_read;
        bus.ex_rt           = s.ex_rt;
        bus.branch_redirect = s.br;
        bus.btb_mispredict  = s.btb;
        bus.exception       = s.exc;
    endtask

    // Called at posedge+1: drive, queue the expectation, advance the model at the edge.
    task automatic step(input string tag, input stim_t s);
        sb_t e;
        apply(s);
        e.tag = tag;
        e.exp = model_out(s);
        sb_q.push_back(e);
        @(posedge clk);
        model_next(s);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents mid-cycle against the queued expectation.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.tag, {23'd0, dut_out()}, {23'd0, e.exp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time %0t exceeded", $time);
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        apply(idle());
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs_zero", {23'd0, dut_out()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load-use hit, release, and r0 immunity.
        s = idle(); s.mem_read = 1; s.ex_rt = 5'd5; s.rs = 5'd5;
        step("load_use_rs", s);
        step("load_use_release", idle());
        s = idle(); s.mem_read = 1; s.ex_rt = 5'd7; s.rt = 5'd7; s.uses_rt = 1;
        step("load_use_rt", s);
        s.uses_rt = 0;
        step("load_use_rt_unused", s);
        s = idle(); s.mem_read = 1; s.ex_rt = 5'd0; s.rs = 5'd0;
        step("load_use_r0", s);

        // Mult/div issue followed by a HI/LO reader.
        s = idle(); s.muldiv = 1; s.hilo = 1;
        step("md_issue", s);
        s = idle(); s.hilo = 1;
        repeat (MD_LAT) step("md_hilo_wait", s);
        step("md_done", idle());

        // Independent traffic during MD_BUSY, then exception at cnt=2.
        s = idle(); s.muldiv = 1; s.hilo = 1;
        step("md_issue2", s);
        s = idle(); s.rs = 5'd3;
        step("md_independent", s);
        s = idle(); s.exc = 1;
        step("exc_in_md_busy", s);
        step("exc_masked_in_drain", s);
        step("drain_last", idle());
        step("run_again", idle());

        // Exception beats a simultaneous mispredict and load-use hit.
        s = idle(); s.exc = 1; s.btb = 1; s.mem_read = 1; s.ex_rt = 5'd5; s.rs = 5'd5;
        step("exc_priority", s);
        s = idle(); s.mem_read = 1; s.ex_rt = 5'd5; s.rs = 5'd5;
        step("drain_load_use", s);
        step("drain_end", idle());

        // Redirects.
        s = idle(); s.btb = 1; s.br = 1;
        step("btb_mispredict", s);
        s = idle(); s.br = 1; s.mem_read = 1; s.ex_rt = 5'd2; s.rs = 5'd2;
        step("branch_redirect", s);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            s.rs       = 5'($urandom_range(0, 3));
            s.rt       = 5'($urandom_range(0, 3));
            s.ex_rt    = 5'($urandom_range(0, 3));
            s.uses_rt  = 1'($urandom_range(0, 1));
            s.mem_read = ($urandom_range(0, 2) == 0);
            s.br       = ($urandom_range(0, 7) == 0);
            s.btb      = ($urandom_range(0, 9) == 0);
            s.exc      = ($urandom_range(0, 15) == 0);
            s.muldiv   = (drain_left == 0) && ($urandom_range(0, 5) == 0);
            s.hilo     = s.muldiv || ($urandom_range(0, 3) == 0);
            step("random", s);
        end
        step("random_settle", idle());
        repeat (MD_LAT + DRAIN) step("random_settle", idle());

        // Asynchronous reset between edges while MD_BUSY.
        s = idle(); s.muldiv = 1; s.hilo = 1;
        step("pre_reset_issue", s);
        step("pre_reset_busy", idle());
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {23'd0, dut_out()}, 32'd0);
        @(posedge clk);
        #1;
        check("reset_held_outputs", {23'd0, dut_out()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        md_left = 0;
        drain_left = 0;
        @(posedge clk);
        #1;
        step("post_reset_run", idle());
        s = idle(); s.hilo = 1;
        step("post_reset_no_hilo_stall", s);

        for (int i = 0; i < 8 && sb_q.size() > 0; i++) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
